// File: rtl/riscky_lsu_pkg.sv
// ---------------------------------------------------------------------------
// riscky_lsu_pkg
// Shared types and helpers for the load/store unit memory controller.
//   lsu_state_e     : controller FSM states
//   F3_*            : RV32I load/store funct3 encodings
//   is_misaligned() : alignment check for a byte offset and funct3
//   is_bad_funct3() : funct3 values that are not a legal load/store
//   lane_extract()  : pick the addressed byte/half/word and extend it
//   lane_merge()    : replace the addressed byte/half inside a word
// ---------------------------------------------------------------------------
package riscky_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] f3);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return (off != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // Stores only have B/H/W forms; the unsigned encodings are illegal there.
    function automatic logic is_bad_funct3(input logic we, input logic [2:0] f3);
        if (we)
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        else
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{s[7]}}, s[7:0]};
            F3_H:    return {{16{s[15]}}, s[15:0]};
            F3_W:    return word;
            F3_BU:   return {24'h0, s[7:0]};
            F3_HU:   return {16'h0, s[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
        logic [31:0] mask;
        logic [4:0]  sh;
        sh = {off, 3'b000};
        case (f3[1:0])
            2'b00:   mask = 32'h0000_00FF;
            2'b01:   mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << sh;
        return (word & ~mask) | ((data << sh) & mask);
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl_if
// Request/response handshake between the MEM stage and the LSU controller.
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                    : response
// Modports: master (pipeline side), slave (controller side).
// ---------------------------------------------------------------------------
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// ---------------------------------------------------------------------------
// lsu_byte_lane
// Combinational lane datapath.
//   mem_word    in  : word read from memory
//   store_data  in  : store data (rs2)
//   byte_off    in  : byte address bits [1:0]
//   funct3      in  : access size / signedness
//   load_data   out : extracted and extended load result
//   merged_word out : mem_word with the addressed byte/half replaced
// ---------------------------------------------------------------------------
module lsu_byte_lane
    import riscky_lsu_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);
    assign load_data   = lane_extract(mem_word, byte_off, funct3);
    assign merged_word = lane_merge(mem_word, store_data, byte_off, funct3);
endmodule

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store initiator for a single-port, word-addressed data memory without
// byte enables. Sub-word stores use a read-modify-write sequence.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : lsu_mem_ctrl_if.slave request/response handshake
//   mem_addr    : word index into memory
//   mem_wdata   : word to write
//   mem_rw      : 1 = write at next clk edge, 0 = combinational read
//   mem_rdata   : memory read data
// Optional build macro: LSU_BOUNDS_CHECK_EN -- addresses at or beyond
// 4*MEM_DEPTH return an error instead of wrapping.
// ---------------------------------------------------------------------------
module lsu_mem_ctrl
    import riscky_lsu_pkg::*;
#(
    parameter int MEM_DEPTH = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    lsu_mem_ctrl_if.slave       bus,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                mem_rw,
    input  logic [31:0]         mem_rdata
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    lsu_state_e  state_reg, state_next;
    logic [2:0]  funct3_reg;
    logic [1:0]  off_reg;
    logic [31:0] wdata_reg;

    logic [31:0] mem_addr_reg,  mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic        mem_rw_reg,    mem_rw_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_err_reg,   rsp_err_next;

    logic        accept;
    logic        req_err;
    logic [31:0] req_index;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign bus.req_ready = (state_reg == ST_IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    // Upper address bits are dropped, so the byte address wraps modulo 4*MEM_DEPTH.
    assign req_index     = 32'(bus.req_addr[IDX_W+1:2]);

`ifdef LSU_BOUNDS_CHECK_EN
    assign req_err = is_bad_funct3(bus.req_we, bus.req_funct3)
                  || is_misaligned(bus.req_addr[1:0], bus.req_funct3)
                  || (bus.req_addr >= 32'(4 * MEM_DEPTH));
`else
    assign req_err = is_bad_funct3(bus.req_we, bus.req_funct3)
                  || is_misaligned(bus.req_addr[1:0], bus.req_funct3);
    logic [31-IDX_W-2:0] unused_addr_hi;
    assign unused_addr_hi = bus.req_addr[31:IDX_W+2];
`endif

    lsu_byte_lane u_lane (
        .mem_word    (mem_rdata),
        .store_data  (wdata_reg),
        .byte_off    (off_reg),
        .funct3      (funct3_reg),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)                   state_next = ST_RESP;
                    else if (!bus.req_we)          state_next = ST_LOAD;
                    else if (bus.req_funct3 == F3_W) state_next = ST_WRITE;
                    else                           state_next = ST_RMW_RD;
                end
            end
            ST_LOAD:   state_next = ST_RESP;
            ST_WRITE:  state_next = ST_RESP;
            ST_RMW_RD: state_next = ST_RMW_WR;
            ST_RMW_WR: state_next = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs. Strobes follow the
    // next state so they are valid for the whole cycle spent in that state.
    always_comb begin
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        rsp_valid_next = (state_next == ST_RESP);
        mem_rw_next    = (state_next == ST_WRITE) || (state_next == ST_RMW_WR);
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    mem_addr_next  = req_index;
                    mem_wdata_next = bus.req_wdata;
                    rsp_rdata_next = 32'h0;
                    rsp_err_next   = req_err;
                end
            end
            ST_LOAD:   rsp_rdata_next = load_data;
            ST_RMW_RD: mem_wdata_next = merged_word;
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_reg    <= 3'b000;
            off_reg       <= 2'b00;
            wdata_reg     <= 32'h0;
            mem_addr_reg  <= 32'h0;
            mem_wdata_reg <= 32'h0;
            mem_rw_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                funct3_reg <= bus.req_funct3;
                off_reg    <= bus.req_addr[1:0];
                wdata_reg  <= bus.req_wdata;
            end
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_rw_reg    <= mem_rw_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign mem_addr      = mem_addr_reg;
    assign mem_wdata     = mem_wdata_reg;
    assign mem_rw        = mem_rw_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Directed bench for lsu_mem_ctrl with a behavioural word-array memory and a
// scoreboard of expected responses.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;
    localparam int MEM_DEPTH = 1024;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if lsu_if ();

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    lsu_mem_ctrl #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (lsu_if.slave),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rw    (mem_rw),
        .mem_rdata (mem_rdata)
    );

    // Behavioural memory: combinational read, write on clock edge when mem_rw=1.
    logic [31:0] mem [MEM_DEPTH];
    logic        tb_we = 1'b0;
    logic [9:0]  tb_waddr = 10'd0;
    logic [31:0] tb_wdata = 32'h0;
    int          wr_count = 0;

    always @(posedge clk) begin
        if (mem_rw) begin
            mem[mem_addr[9:0]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end else if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[9:0]];

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        tb_we    = 1'b1;
        tb_waddr = idx[9:0];
        tb_wdata = val;
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_writes, input int hold);
        exp_t e;
        int   lat;
        int   w0;
        e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.writes = exp_writes;
        sb.push_back(e);
        @(negedge clk);
        check({tag, ".req_ready"}, 32'(lsu_if.req_ready), 32'd1);
        lsu_if.req_valid  = 1'b1;
        lsu_if.req_we     = we;
        lsu_if.req_funct3 = f3;
        lsu_if.req_addr   = addr;
        lsu_if.req_wdata  = wdata;
        lsu_if.rsp_ready  = (hold == 0);
        w0 = wr_count;
        @(posedge clk);
        #1;
        // Inputs are don't-care after acceptance: scramble them.
        lsu_if.req_valid  = 1'b0;
        lsu_if.req_we     = 1'($urandom);
        lsu_if.req_funct3 = 3'($urandom);
        lsu_if.req_addr   = $urandom;
        lsu_if.req_wdata  = $urandom;
        lat = 1;
        @(negedge clk);
        while (lsu_if.rsp_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check({tag, ".latency"}, 32'(lat), 32'(e.lat));
        check({tag, ".rdata"}, lsu_if.rsp_rdata, e.rdata);
        check({tag, ".err"}, 32'(lsu_if.rsp_err), 32'(e.err));
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                check({tag, ".hold_valid"}, 32'(lsu_if.rsp_valid), 32'd1);
                check({tag, ".hold_rdata"}, lsu_if.rsp_rdata, e.rdata);
                check({tag, ".hold_ready"}, 32'(lsu_if.req_ready), 32'd0);
            end
            lsu_if.rsp_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, ".valid_drop"}, 32'(lsu_if.rsp_valid), 32'd0);
        check({tag, ".idle"}, 32'(lsu_if.req_ready), 32'd1);
        check({tag, ".writes"}, 32'(wr_count - w0), 32'(e.writes));
        $display("txn %s we=%0b f3=%03b addr=%h lat=%0d rdata=%h err=%0b",
                 tag, we, f3, addr, lat, lsu_if.rsp_rdata, lsu_if.rsp_err);
    endtask

    initial begin
        int w0;
        lsu_if.req_valid  = 1'b0;
        lsu_if.req_we     = 1'b0;
        lsu_if.req_funct3 = 3'b000;
        lsu_if.req_addr   = 32'h0;
        lsu_if.req_wdata  = 32'h0;
        lsu_if.rsp_ready  = 1'b1;

        // Memory preload while held in reset.
        preload(0, 32'h1234_5678);
        preload(5, 32'h8081_F2A4);
        preload(8, 32'h0000_0000);
        preload(9, 32'h0F0F_0F0F);

        check("rst.req_ready", 32'(lsu_if.req_ready), 32'd1);
        check("rst.rsp_valid", 32'(lsu_if.rsp_valid), 32'd0);
        check("rst.rsp_rdata", lsu_if.rsp_rdata, 32'h0);
        check("rst.rsp_err",   32'(lsu_if.rsp_err), 32'd0);
        check("rst.mem_rw",    32'(mem_rw), 32'd0);
        check("rst.mem_addr",  mem_addr, 32'h0);
        check("rst.mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //      tag      we    f3      addr          wdata         rdata         err  lat wr hold
        do_req("lb15",  1'b0, 3'b000, 32'h0000_0015, 32'h0,        32'hFFFF_FFF2, 1'b0, 2, 0, 0);
        do_req("lhu16", 1'b0, 3'b101, 32'h0000_0016, 32'h0,        32'h0000_8081, 1'b0, 2, 0, 0);
        do_req("lw14",  1'b0, 3'b010, 32'h0000_0014, 32'h0,        32'h8081_F2A4, 1'b0, 2, 0, 0);
        do_req("lh14",  1'b0, 3'b001, 32'h0000_0014, 32'h0,        32'hFFFF_F2A4, 1'b0, 2, 0, 0);
        do_req("lbu14", 1'b0, 3'b100, 32'h0000_0014, 32'h0,        32'h0000_00A4, 1'b0, 2, 0, 0);
        do_req("sb17",  1'b1, 3'b000, 32'h0000_0017, 32'h0000_00AB, 32'h0,       1'b0, 3, 1, 0);
        check("sb17.mem5", mem[5], 32'hAB81_F2A4);
        do_req("sh14",  1'b1, 3'b001, 32'h0000_0014, 32'hFFFF_1234, 32'h0,       1'b0, 3, 1, 0);
        check("sh14.mem5", mem[5], 32'hAB81_1234);
        do_req("sw20",  1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,       1'b0, 2, 1, 0);
        check("sw20.mem8", mem[8], 32'hDEAD_BEEF);
        do_req("lw20",  1'b0, 3'b010, 32'h0000_0020, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 0, 0);
        do_req("lw02",  1'b0, 3'b010, 32'h0000_0002, 32'h0,        32'h0,         1'b1, 1, 0, 0);
        do_req("lh03",  1'b0, 3'b001, 32'h0000_0003, 32'h0,        32'h0,         1'b1, 1, 0, 0);
        do_req("sw01",  1'b1, 3'b010, 32'h0000_0021, 32'h5555_5555, 32'h0,        1'b1, 1, 0, 0);
        check("sw01.mem8", mem[8], 32'hDEAD_BEEF);
        do_req("f3_011", 1'b0, 3'b011, 32'h0000_0000, 32'h0,       32'h0,         1'b1, 1, 0, 0);
        do_req("hold",  1'b0, 3'b010, 32'h0000_0014, 32'h0,        32'hAB81_1234, 1'b0, 2, 0, 5);
`ifdef LSU_BOUNDS_CHECK_EN
        do_req("lw1000", 1'b0, 3'b010, 32'h0000_1000, 32'h0,       32'h0,         1'b1, 1, 0, 0);
`else
        do_req("lw1000", 1'b0, 3'b010, 32'h0000_1000, 32'h0,       32'h1234_5678, 1'b0, 2, 0, 0);
`endif

        // Reset asserted while the controller sits in RMW_WR.
        @(negedge clk);
        lsu_if.req_valid  = 1'b1;
        lsu_if.req_we     = 1'b1;
        lsu_if.req_funct3 = 3'b000;
        lsu_if.req_addr   = 32'h0000_0025;
        lsu_if.req_wdata  = 32'h0000_0055;
        w0 = wr_count;
        @(posedge clk);
        #1;
        lsu_if.req_valid = 1'b0;
        @(negedge clk);
        check("rstmid.rmw_rd_rw", 32'(mem_rw), 32'd0);
        @(negedge clk);
        check("rstmid.rmw_wr_rw", 32'(mem_rw), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid.async_rw", 32'(mem_rw), 32'd0);
        check("rstmid.req_ready", 32'(lsu_if.req_ready), 32'd1);
        @(negedge clk);
        check("rstmid.mem9", mem[9], 32'h0F0F_0F0F);
        check("rstmid.writes", 32'(wr_count - w0), 32'd0);
        check("rstmid.rsp_valid", 32'(lsu_if.rsp_valid), 32'd0);
        $display("txn rstmid sb addr=00000025 aborted mem9=%h", mem[9]);
        rst_n = 1'b1;

        do_req("post_lw24", 1'b0, 3'b010, 32'h0000_0024, 32'h0,    32'h0F0F_0F0F, 1'b0, 2, 0, 0);
        do_req("post_sb26", 1'b1, 3'b000, 32'h0000_0026, 32'h0000_0077, 32'h0,   1'b0, 3, 1, 0);
        check("post_sb26.mem9", mem[9], 32'h0F77_0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
